bus_sequencer: RTL and testbench

Sequences register-to-register moves over the shared 8-bit tri-state data bus. Multiple requesters each ask for one move (source register → destination register). The block arbitrates round-robin, then drives the per-register `reg_op_e` controls through a fixed PRIME/XFER sequence. The sequence is sized so the source register's internal output latch is refreshed before the destination loads. The block sits between the control unit / microsequencer and the bank of bus registers, and is the only driver of their `op` inputs.

---
 rtl/bus_sequencer.sv | 147 ++++++++++++++
 tb/tb_bus_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_sequencer.sv
// Bus move sequencer: round-robin arbitration of register-to-register moves,
// driving per-register ENABLE/LOAD controls through a PRIME/XFER/DONE sequence.
package bus_sequencer_pkg;
    typedef enum logic [1:0] {
        REG_NOP    = 2'b00,
        REG_ENABLE = 2'b01,
        REG_LOAD   = 2'b10
    } reg_op_e;
endpackage

module bus_sequencer
    import bus_sequencer_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int N_REG = 4,
    parameter int IDXW  = 4,
    localparam int GW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [N_REQ*IDXW-1:0] req_src,
    input  logic [N_REQ*IDXW-1:0] req_dst,
    output logic [N_REQ-1:0]      req_done,
    output logic                  req_err,
    output logic [N_REG-1:0][1:0] reg_op,
    output logic                  busy,
    output logic [GW-1:0]         grant_id,
    output logic [7:0]            xfer_count
);
    typedef enum logic [1:0] {ST_IDLE, ST_PRIME, ST_XFER, ST_DONE} state_e;

    state_e          state_q, state_d;
    logic [GW-1:0]   rrPtr_q, rrPtr_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [IDXW-1:0] src_q, src_d;
    logic [IDXW-1:0] dst_q, dst_d;
    logic            err_q, err_d;
    logic [7:0]      count_q, count_d;

    logic            anyValid;
    logic [GW-1:0]   pick;
    logic [IDXW-1:0] pickSrc, pickDst;
    logic            pickBad;

    // The first loop finds the lowest requester overall (the wrap-around
    // candidate); the second overrides it with the lowest one at or after rrPtr.
    always_comb begin
        anyValid = |req_valid;
        pick     = rrPtr_q;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                pick = GW'(i);
            end
        end
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_valid[i] && (GW'(i) >= rrPtr_q)) begin
                pick = GW'(i);
            end
        end
        pickSrc = '0;
        pickDst = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (GW'(i) == pick) begin
                pickSrc = req_src[i*IDXW +: IDXW];
                pickDst = req_dst[i*IDXW +: IDXW];
            end
        end
        pickBad = (pickSrc == pickDst)
               || ({1'b0, pickSrc} >= (IDXW+1)'(N_REG))
               || ({1'b0, pickDst} >= (IDXW+1)'(N_REG));
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            rrPtr_q <= '0;
            grant_q <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            err_q   <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            rrPtr_q <= rrPtr_d;
            grant_q <= grant_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            err_q   <= err_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rrPtr_d = rrPtr_q;
        grant_d = grant_q;
        src_d   = src_q;
        dst_d   = dst_q;
        err_d   = err_q;
        count_d = count_q;
        unique case (state_q)
            ST_IDLE: begin
                if (anyValid) begin
                    grant_d = pick;
                    src_d   = pickSrc;
                    dst_d   = pickDst;
                    err_d   = pickBad;
                    rrPtr_d = (pick == GW'(N_REQ - 1)) ? '0 : pick + 1'b1;
                    state_d = pickBad ? ST_DONE : ST_PRIME;
                end
            end
            ST_PRIME: state_d = ST_XFER;
            ST_XFER:  state_d = ST_DONE;
            ST_DONE: begin
                if (!err_q) begin
                    count_d = count_q + 8'd1;
                end
                state_d = ST_IDLE;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // Source stays enabled through XFER so the bus holds its refreshed value
    // while the destination loads.
    always_comb begin
        busy       = (state_q != ST_IDLE);
        grant_id   = grant_q;
        req_err    = (state_q == ST_DONE) && err_q;
        xfer_count = count_q;
        req_done   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if ((state_q == ST_DONE) && (GW'(i) == grant_q)) begin
                req_done[i] = 1'b1;
            end
        end
        for (int r = 0; r < N_REG; r++) begin
            reg_op[r] = REG_NOP;
            if (((state_q == ST_PRIME) || (state_q == ST_XFER)) && (IDXW'(r) == src_q)) begin
                reg_op[r] = REG_ENABLE;
            end else if ((state_q == ST_XFER) && (IDXW'(r) == dst_q)) begin
                reg_op[r] = REG_LOAD;
            end
        end
    end
endmodule

// File: tb/tb_bus_sequencer.sv
// Directed and randomised checks of bus_sequencer against a transaction-level
// model of grants, move timing and the move counter.
module tb_bus_sequencer;
    import bus_sequencer_pkg::*;

    localparam int NREQ = 2;
    localparam int NREG = 4;
    localparam int IDXW = 4;

    logic                 clock = 1'b0;
    logic                 reset = 1'b0;
    logic [NREQ-1:0]      reqValid = '0;
    logic [NREQ*IDXW-1:0] reqSrc = '0;
    logic [NREQ*IDXW-1:0] reqDst = '0;
    logic [NREQ-1:0]      reqDone;
    logic                 reqErr;
    logic [NREG-1:0][1:0] regOp;
    logic                 busy;
    logic [0:0]           grantId;
    logic [7:0]           xferCount;

    int checks = 0;
    int errors = 0;

    bus_sequencer #(.N_REQ(NREQ), .N_REG(NREG), .IDXW(IDXW)) dut (
        .clock(clock), .reset(reset), .req_valid(reqValid), .req_src(reqSrc),
        .req_dst(reqDst), .req_done(reqDone), .req_err(reqErr), .reg_op(regOp),
        .busy(busy), .grant_id(grantId), .xfer_count(xferCount)
    );

    always #5 clock = ~clock;

    // Register bank on the shared bus: r1 powers up holding 0x5A.
    logic [7:0] regFile [NREG];
    logic [7:0] busVal;
    always_comb begin
        busVal = 8'h00;
        for (int r = 0; r < NREG; r++) if (regOp[r] == REG_ENABLE) busVal = regFile[r];
    end
    always @(posedge clock) begin
        for (int r = 0; r < NREG; r++) begin
            if (!reset) regFile[r] <= (r == 1) ? 8'h5A : 8'h00;
            else if (regOp[r] == REG_LOAD) regFile[r] <= busVal;
        end
    end

    // Transaction model: mPhase counts cycles since the grant, a move lasts 3
    // cycles (done on the last) and a rejected one lasts 1.
    int mPhase = 0, mLen = 0, mGrant = 0, mSrc = 0, mDst = 0, mRr = 0, mCount = 0;
    bit mErr = 1'b0;

    function automatic int pickGrant(input logic [NREQ-1:0] v, input int ptr);
        for (int k = 0; k < NREQ; k++) if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        return -1;
    endfunction

    always @(posedge clock) begin
        if (!reset) begin
            mPhase = 0; mRr = 0; mCount = 0; mErr = 1'b0; mGrant = 0;
        end else if (mPhase == 0) begin
            if (reqValid != '0) begin
                mGrant = pickGrant(reqValid, mRr);
                mSrc   = int'(reqSrc[mGrant*IDXW +: IDXW]);
                mDst   = int'(reqDst[mGrant*IDXW +: IDXW]);
                mErr   = (mSrc == mDst) || (mSrc >= NREG) || (mDst >= NREG);
                mLen   = mErr ? 1 : 3;
                mPhase = 1;
                mRr    = (mGrant + 1) % NREQ;
            end
        end else if (mPhase == mLen) begin
            if (!mErr) mCount = (mCount + 1) % 256;
            mPhase = 0;
        end else begin
            mPhase = mPhase + 1;
        end
    end

    function automatic logic [NREG-1:0][1:0] modelOps();
        logic [NREG-1:0][1:0] ops = '0;
        if (!mErr && (mPhase == 1 || mPhase == 2)) begin
            ops[mSrc] = REG_ENABLE;
            if (mPhase == 2) ops[mDst] = REG_LOAD;
        end
        return ops;
    endfunction

    function automatic logic [IDXW-1:0] randIdx();
        if ($urandom_range(0, 7) == 0) return IDXW'($urandom_range(4, 15));
        return IDXW'($urandom_range(0, 3));
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        reqValid = '0;
        repeat (2) @(negedge clock);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %0b want 0", busy); end
        checks++; if (reqDone !== 2'b00) begin errors++; $display("[TB] FAIL reset_done got %b want 00", reqDone); end
        checks++; if (reqErr !== 1'b0) begin errors++; $display("[TB] FAIL reset_err got %0b want 0", reqErr); end
        checks++; if (grantId !== 1'b0) begin errors++; $display("[TB] FAIL reset_grant got %0d want 0", grantId); end
        checks++; if (regOp !== '0) begin errors++; $display("[TB] FAIL reset_ops got %h want 00", regOp); end
        checks++; if (xferCount !== 8'd0) begin errors++; $display("[TB] FAIL reset_count got %0d want 0", xferCount); end
        reset = 1'b1;
    endtask

    task automatic test_single_move();
        logic [1:0] wantEn, wantLd;
        logic [1:0] wantDone;
        reqSrc[3:0] = 4'd1; reqDst[3:0] = 4'd2; reqValid[0] = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clock);
            wantEn   = (k == 1 || k == 2) ? REG_ENABLE : REG_NOP;
            wantLd   = (k == 2) ? REG_LOAD : REG_NOP;
            wantDone = (k == 3) ? 2'b01 : 2'b00;
            checks++; if (regOp[1] !== wantEn) begin errors++; $display("[TB] FAIL single_src_op cycle %0d got %0d want %0d", k, regOp[1], wantEn); end
            checks++; if (regOp[2] !== wantLd) begin errors++; $display("[TB] FAIL single_dst_op cycle %0d got %0d want %0d", k, regOp[2], wantLd); end
            checks++; if (reqDone !== wantDone) begin errors++; $display("[TB] FAIL single_done cycle %0d got %b want %b", k, reqDone, wantDone); end
            if (k == 3) reqValid[0] = 1'b0;
        end
        checks++; if (regFile[2] !== 8'h5A) begin errors++; $display("[TB] FAIL single_r2 got %h want 5a", regFile[2]); end
        checks++; if (xferCount !== 8'd1) begin errors++; $display("[TB] FAIL single_count got %0d want 1", xferCount); end
    endtask

    task automatic test_round_robin();
        logic [1:0] wantDone;
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        reqSrc = {4'd3, 4'd1}; reqDst = {4'd0, 4'd2}; reqValid = 2'b11;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clock);
            wantDone = (k == 3 || k == 11) ? 2'b01 : (k == 7 || k == 15) ? 2'b10 : 2'b00;
            checks++; if (reqDone !== wantDone) begin errors++; $display("[TB] FAIL rr_done cycle %0d got %b want %b", k, reqDone, wantDone); end
            if (k % 4 == 1) begin
                checks++; if (grantId !== 1'((k / 4) % 2)) begin errors++; $display("[TB] FAIL rr_grant cycle %0d got %0d want %0d", k, grantId, (k / 4) % 2); end
            end
            if (k == 11) reqValid[0] = 1'b0;
            if (k == 15) reqValid[1] = 1'b0;
        end
        checks++; if (xferCount !== 8'd4) begin errors++; $display("[TB] FAIL rr_count got %0d want 4", xferCount); end
    endtask

    task automatic test_invalid();
        logic [3:0] srcs [2] = '{4'd2, 4'd1};
        logic [3:0] dsts [2] = '{4'd2, 4'd7};
        for (int t = 0; t < 2; t++) begin
            reqSrc[3:0] = srcs[t]; reqDst[3:0] = dsts[t]; reqValid[0] = 1'b1;
            @(negedge clock);
            checks++; if (reqDone !== 2'b01) begin errors++; $display("[TB] FAIL inv_done case %0d got %b want 01", t, reqDone); end
            checks++; if (reqErr !== 1'b1) begin errors++; $display("[TB] FAIL inv_err case %0d got %0b want 1", t, reqErr); end
            checks++; if (regOp !== '0) begin errors++; $display("[TB] FAIL inv_ops case %0d got %h want 00", t, regOp); end
            reqValid[0] = 1'b0;
            @(negedge clock);
            checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL inv_idle case %0d got %0b want 0", t, busy); end
            checks++; if (regOp !== '0) begin errors++; $display("[TB] FAIL inv_ops_after case %0d got %h want 00", t, regOp); end
        end
        checks++; if (xferCount !== 8'd4) begin errors++; $display("[TB] FAIL inv_count got %0d want 4", xferCount); end
    endtask

    task automatic test_reset_mid_move();
        reqSrc[3:0] = 4'd0; reqDst[3:0] = 4'd3; reqValid[0] = 1'b1;
        @(negedge clock);
        checks++; if (regOp[0] !== REG_ENABLE) begin errors++; $display("[TB] FAIL mid_prime got %0d want %0d", regOp[0], REG_ENABLE); end
        @(negedge clock);
        checks++; if (regOp[3] !== REG_LOAD) begin errors++; $display("[TB] FAIL mid_xfer got %0d want %0d", regOp[3], REG_LOAD); end
        reset = 1'b0;
        @(negedge clock);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_busy got %0b want 0", busy); end
        checks++; if (regOp !== '0) begin errors++; $display("[TB] FAIL mid_ops got %h want 00", regOp); end
        checks++; if (reqDone !== 2'b00) begin errors++; $display("[TB] FAIL mid_done got %b want 00", reqDone); end
        checks++; if (xferCount !== 8'd0) begin errors++; $display("[TB] FAIL mid_count got %0d want 0", xferCount); end
        reset = 1'b1;
        @(negedge clock);
        checks++; if (regOp[0] !== REG_ENABLE || regOp[3] !== REG_NOP) begin errors++; $display("[TB] FAIL mid_restart_prime got %h want 01", regOp); end
        @(negedge clock);
        checks++; if (regOp[3] !== REG_LOAD) begin errors++; $display("[TB] FAIL mid_restart_xfer got %0d want %0d", regOp[3], REG_LOAD); end
        @(negedge clock);
        checks++; if (reqDone !== 2'b01) begin errors++; $display("[TB] FAIL mid_restart_done got %b want 01", reqDone); end
        reqValid[0] = 1'b0;
        @(negedge clock);
        checks++; if (xferCount !== 8'd1) begin errors++; $display("[TB] FAIL mid_restart_count got %0d want 1", xferCount); end
    endtask

    task automatic test_field_change();
        reqSrc[3:0] = 4'd1; reqDst[3:0] = 4'd2; reqValid[0] = 1'b1;
        @(negedge clock);
        checks++; if (regOp[1] !== REG_ENABLE) begin errors++; $display("[TB] FAIL fld_prime got %0d want %0d", regOp[1], REG_ENABLE); end
        reqSrc[3:0] = 4'd0; reqDst[3:0] = 4'd3;
        @(negedge clock);
        checks++; if (regOp !== {REG_NOP, REG_LOAD, REG_ENABLE, REG_NOP}) begin errors++; $display("[TB] FAIL fld_xfer got %h want 24", regOp); end
        @(negedge clock);
        checks++; if (reqDone !== 2'b01) begin errors++; $display("[TB] FAIL fld_done got %b want 01", reqDone); end
        reqValid[0] = 1'b0;
        @(negedge clock);
        checks++; if (xferCount !== 8'd2) begin errors++; $display("[TB] FAIL fld_count got %0d want 2", xferCount); end
    endtask

    task automatic test_counter_wrap();
        int doneSeen = 0;
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        reqSrc[3:0] = 4'd1; reqDst[3:0] = 4'd2; reqValid[0] = 1'b1;
        for (int c = 1; c <= 1024; c++) begin
            @(negedge clock);
            if (reqDone[0]) doneSeen++;
            if (c == 1020) begin
                checks++; if (xferCount !== 8'd255) begin errors++; $display("[TB] FAIL wrap_255 got %0d want 255", xferCount); end
            end
        end
        reqValid[0] = 1'b0;
        checks++; if (xferCount !== 8'd0) begin errors++; $display("[TB] FAIL wrap_zero got %0d want 0", xferCount); end
        checks++; if (doneSeen != 256) begin errors++; $display("[TB] FAIL wrap_dones got %0d want 256", doneSeen); end
    endtask

    task automatic test_random();
        bit active [NREQ];
        bit expBusy, expDone;
        logic [NREQ-1:0] expDoneVec;
        logic [NREG-1:0][1:0] expOps;
        for (int i = 0; i < NREQ; i++) active[i] = 1'b0;
        reqValid = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clock);
            expBusy    = (mPhase != 0);
            expDone    = (mPhase != 0) && (mPhase == mLen);
            expDoneVec = expDone ? (NREQ'(1) << mGrant) : '0;
            expOps     = modelOps();
            checks++; if (busy !== expBusy) begin errors++; $display("[TB] FAIL rnd_busy cycle %0d got %0b want %0b", cyc, busy, expBusy); end
            checks++; if (reqDone !== expDoneVec) begin errors++; $display("[TB] FAIL rnd_done cycle %0d got %b want %b", cyc, reqDone, expDoneVec); end
            checks++; if (reqErr !== (expDone && mErr)) begin errors++; $display("[TB] FAIL rnd_err cycle %0d got %0b want %0b", cyc, reqErr, expDone && mErr); end
            checks++; if (regOp !== expOps) begin errors++; $display("[TB] FAIL rnd_ops cycle %0d got %h want %h", cyc, regOp, expOps); end
            checks++; if (xferCount !== 8'(mCount)) begin errors++; $display("[TB] FAIL rnd_count cycle %0d got %0d want %0d", cyc, xferCount, mCount); end
            if (expBusy) begin
                checks++; if (grantId !== 1'(mGrant)) begin errors++; $display("[TB] FAIL rnd_grant cycle %0d got %0d want %0d", cyc, grantId, mGrant); end
            end
            for (int i = 0; i < NREQ; i++) begin
                if (expDone && mGrant == i) active[i] = 1'b0;
                if (!active[i] && $urandom_range(0, 2) == 0) begin
                    active[i] = 1'b1;
                    reqSrc[i*IDXW +: IDXW] = randIdx();
                    reqDst[i*IDXW +: IDXW] = randIdx();
                end
                reqValid[i] = active[i];
            end
            reset = ($urandom_range(0, 199) != 0);
        end
        reset = 1'b1;
        reqValid = '0;
    endtask

    initial begin
        test_reset();
        test_single_move();
        test_round_robin();
        test_invalid();
        test_reset_mid_move();
        test_field_change();
        test_counter_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
